ahb_lite_sn: RTL and testbench
==============================

// Module: ahb_lite_sn
// PURPOSE
//  Parametrised AHB-Lite single-master to N-slave interconnect: address decoder, registered
//  data-phase mux, built-in default slave that returns the two-cycle ERROR response.
//  Next generation of the fixed 3-slave fabric. Sits between a master (or the ahb2ahb bridge
//  master side) and up to 8 memory-mapped AHB slaves.
// PARAMETERS
//  NUM_SLV   3                 number of slaves, 1..8
//  P_START   {16'h2000,16'h1000,16'h0000}  NUM_SLV x 16b region bases, compared to HADDR[31:16], slave0 in LSBs
//  P_SIZE    {3{16'h0100}}     NUM_SLV x 16b region sizes, same unit; size 0 disables the slave
// PORTS
//  HCLK      in   1          clock, all logic on rising edge
//  HRESETn   in   1          asynchronous active-low reset
//  M_HADDR   in   32         master address
//  M_HTRANS  in   2          master transfer type
//  M_HWRITE  in   1          master write
//  M_HSIZE   in   3          master size
//  M_HBURST  in   3          master burst
//  M_HPROT   in   4          master protection
//  M_HWDATA  in   32         master write data
//  M_HRDATA  out  32         read data muxed from data-phase owner
//  M_HRESP   out  2          response muxed from data-phase owner (00 OKAY, 01 ERROR)
//  M_HREADY  out  1          ready muxed from data-phase owner
//  HADDR,HTRANS,HWRITE,HSIZE,HBURST,HPROT,HWDATA  out  as master   broadcast to all slaves
//  HREADY    out  1          copy of M_HREADY, broadcast to all slaves
//  HSEL      out  NUM_SLV    one-hot address-phase select
//  HRDATA    in   NUM_SLV*32 slave read data, slave i at [32i+31:32i]
//  HRESP     in   NUM_SLV*2  slave responses
//  HREADYout in   NUM_SLV    slave ready outputs
//  REMAP     in   1          remap control (see CONFIGURATION)
// BEHAVIOUR
//  - Decode (comb): slave i hit when P_START_i <= HADDR[31:16] < P_START_i+P_SIZE_i (17-bit sum,
//    no wrap). Overlaps: lowest index wins. No hit -> default slave (DS). HSEL driven regardless of HTRANS.
//  - Data-phase owner reg dsel: loads decoded owner (incl. DS) on rising HCLK when M_HREADY=1.
//    Holds while M_HREADY=0. Reset value: DS.
//  - M_HRDATA/M_HRESP/M_HREADY = signals of dsel. When dsel=DS: HRDATA=0, response from DS FSM.
//    Zero added latency: no register in address or response paths.
//  - DS FSM states IDLE, ERR1, ERR2. Reset: IDLE.
//    - IDLE: outputs HREADY=1, HRESP=OKAY.
//      Go to ERR1 when M_HREADY=1, no slave hit, and HTRANS is NONSEQ(10) or SEQ(11).
//      IDLE/BUSY transfers to an unmapped address get a zero-wait OKAY.
//    - ERR1: outputs HREADY=0, HRESP=ERROR; always goes to ERR2.
//    - ERR2: outputs HREADY=1, HRESP=ERROR.
//      Goes to ERR1 if another unmapped NONSEQ/SEQ is in the address phase, else IDLE.
//  - Back-to-back: an error at DS followed by an access to a valid slave moves dsel on the ERR2
//    edge; no bubble.
//  - Reset mid-transfer: dsel=DS and FSM=IDLE immediately (async).
//    M_HREADY=1, M_HRESP=00, M_HRDATA=0 while HRESETn=0.
// CONFIGURATION
//  AHB_LITE_REMAP_EN defined:
//    - While REMAP=1, the decoded selections of slave 0 and slave 1 are swapped (requires NUM_SLV>=2).
//    - REMAP is sampled with the address phase, so a change never affects a data phase in flight.
//  Undefined: REMAP is ignored, decode is as parametrised.
// TESTING
//  1 Reset: HRESETn=0 -> M_HREADY=1, M_HRESP=00, M_HRDATA=0, HSEL=000.
//  2 Write 0xCAFE0001 to 0x1000_0004, then read it back.
//    -> HSEL=010 in the address phase; read returns 0xCAFE0001 from slave1 with OKAY.
//  3 NONSEQ read at 0x5000_0000 (unmapped).
//    -> cycle1 HREADY=0/HRESP=01, cycle2 HREADY=1/HRESP=01, M_HRDATA=0.
//    -> Same address with HTRANS=IDLE gives OKAY, zero wait.
//  4 Slave2 (0x2000_0000) inserts 3 wait states while the next address hits slave0.
//    -> dsel holds slave2 until its HREADYout=1; slave0 data follows with no bubble.
//  5 INCR4 to 0x0000_0000 with HRESETn pulsed low after beat 2.
//    -> outputs go to reset values within the same cycle; DS FSM=IDLE.
//  6 With AHB_LITE_REMAP_EN and REMAP=1: read 0x0000_0000 -> HSEL=010 (slave1 responds);
//    REMAP=0 -> HSEL=001.

Source files
------------

// File: rtl/ahb_lite_sn.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_sn
// Brief    : AHB-Lite single-master to NUM_SLV-slave interconnect with address
//            decoder, data-phase response mux and built-in ERROR default slave.
//            Optional macro AHB_LITE_REMAP_EN swaps slave 0/1 decode while REMAP=1.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_sn #(
  parameter int                    NUM_SLV = 3,
  parameter logic [NUM_SLV*16-1:0] P_START = {16'h2000, 16'h1000, 16'h0000},
  parameter logic [NUM_SLV*16-1:0] P_SIZE  = {3{16'h0100}}
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           M_HADDR,
  input  logic [1:0]            M_HTRANS,
  input  logic                  M_HWRITE,
  input  logic [2:0]            M_HSIZE,
  input  logic [2:0]            M_HBURST,
  input  logic [3:0]            M_HPROT,
  input  logic [31:0]           M_HWDATA,
  output logic [31:0]           M_HRDATA,
  output logic [1:0]            M_HRESP,
  output logic                  M_HREADY,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [31:0]           HWDATA,
  output logic                  HREADY,
  output logic [NUM_SLV-1:0]    HSEL,
  input  logic [NUM_SLV*32-1:0] HRDATA,
  input  logic [NUM_SLV*2-1:0]  HRESP,
  input  logic [NUM_SLV-1:0]    HREADYout,
  input  logic                  REMAP
);

  localparam int              c_IW    = $clog2(NUM_SLV + 1);
  localparam logic [c_IW-1:0] c_DS    = c_IW'(NUM_SLV);
  localparam logic [1:0]      c_OKAY  = 2'b00;
  localparam logic [1:0]      c_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [NUM_SLV-1:0] w_hit;
  logic [NUM_SLV-1:0] w_sel_pri;
  logic [NUM_SLV-1:0] w_sel;
  logic               w_any_hit;
  logic [c_IW-1:0]    w_owner;
  logic [c_IW-1:0]    r_dsel;
  logic               w_dsel_ds;
  logic               w_slv_ready;
  logic [1:0]         w_slv_resp;
  logic [31:0]        w_slv_rdata;
  ds_state_t          r_ds_state;
  ds_state_t          w_ds_next;
  logic               w_ds_ready;
  logic [1:0]         w_ds_resp;
  logic               w_ds_go;

  // Region check uses a 17-bit limit so a region ending at 0xFFFF does not wrap.
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
    logic [15:0] w_base;
    logic [16:0] w_lim;
    assign w_base    = P_START[16*gi +: 16];
    assign w_lim     = {1'b0, w_base} + {1'b0, P_SIZE[16*gi +: 16]};
    assign w_hit[gi] = (M_HADDR[31:16] >= w_base) && ({1'b0, M_HADDR[31:16]} < w_lim);
  end

  // Isolate the lowest set bit: overlapping regions resolve to the lowest index.
  assign w_sel_pri = w_hit & (~w_hit + NUM_SLV'(1));
  assign w_any_hit = |w_hit;

`ifdef AHB_LITE_REMAP_EN
  if (NUM_SLV >= 2) begin : g_remap
    always_comb begin
      w_sel = w_sel_pri;
      if (REMAP) begin
        w_sel[0] = w_sel_pri[1];
        w_sel[1] = w_sel_pri[0];
      end
    end
  end else begin : g_no_remap
    logic w_unused_remap;
    assign w_unused_remap = REMAP;
    assign w_sel          = w_sel_pri;
  end
`else
  logic w_unused_remap;
  assign w_unused_remap = REMAP;
  assign w_sel          = w_sel_pri;
`endif

  always_comb begin
    w_owner = c_DS;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_sel[i]) w_owner = c_IW'(i);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      r_dsel <= c_DS;
    else if (M_HREADY) r_dsel <= w_owner;
  end

  // Slave-side mux only; defaults (ready, OKAY, zero data) stand when the DS owns the data phase.
  always_comb begin
    w_slv_ready = 1'b1;
    w_slv_resp  = c_OKAY;
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_dsel == c_IW'(i)) begin
        w_slv_ready = HREADYout[i];
        w_slv_resp  = HRESP[2*i +: 2];
        w_slv_rdata = HRDATA[32*i +: 32];
      end
    end
  end

  // w_slv_ready reads 1 when the DS owns the bus, which matches the DS in IDLE/ERR2,
  // the only states that consult w_ds_go; this keeps the FSM free of a comb loop.
  assign w_ds_go = w_slv_ready & ~w_any_hit & M_HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_ds_state <= DS_IDLE;
    else          r_ds_state <= w_ds_next;
  end

  always_comb begin
    w_ds_next  = r_ds_state;
    w_ds_ready = 1'b1;
    w_ds_resp  = c_OKAY;
    case (r_ds_state)
      DS_IDLE: begin
        if (w_ds_go) w_ds_next = DS_ERR1;
      end
      DS_ERR1: begin
        w_ds_ready = 1'b0;
        w_ds_resp  = c_ERROR;
        w_ds_next  = DS_ERR2;
      end
      DS_ERR2: begin
        w_ds_resp = c_ERROR;
        w_ds_next = w_ds_go ? DS_ERR1 : DS_IDLE;
      end
      default: w_ds_next = DS_IDLE;
    endcase
  end

  assign w_dsel_ds = (r_dsel == c_DS);
  assign M_HREADY  = w_dsel_ds ? w_ds_ready : w_slv_ready;
  assign M_HRESP   = w_dsel_ds ? w_ds_resp  : w_slv_resp;
  assign M_HRDATA  = w_slv_rdata;

  assign HADDR  = M_HADDR;
  assign HTRANS = M_HTRANS;
  assign HWRITE = M_HWRITE;
  assign HSIZE  = M_HSIZE;
  assign HBURST = M_HBURST;
  assign HPROT  = M_HPROT;
  assign HWDATA = M_HWDATA;
  assign HREADY = M_HREADY;
  assign HSEL   = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sn.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_sn
// Brief    : Scoreboard bench for ahb_lite_sn with three memory slave models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_sn;

  localparam int         NUM_SLV  = 3;
  localparam logic [1:0] c_IDLE   = 2'b00;
  localparam logic [1:0] c_NONSEQ = 2'b10;
  localparam logic [1:0] c_SEQ    = 2'b11;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_ERR    = 2'b01;

  logic                  HCLK;
  logic                  HRESETn;
  logic                  tb_srst_n;
  logic [31:0]           M_HADDR;
  logic [1:0]            M_HTRANS;
  logic                  M_HWRITE;
  logic [2:0]            M_HSIZE;
  logic [2:0]            M_HBURST;
  logic [3:0]            M_HPROT;
  logic [31:0]           M_HWDATA;
  logic [31:0]           M_HRDATA;
  logic [1:0]            M_HRESP;
  logic                  M_HREADY;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic [NUM_SLV-1:0]    HSEL;
  logic [NUM_SLV*32-1:0] HRDATA;
  logic [NUM_SLV*2-1:0]  HRESP;
  logic [NUM_SLV-1:0]    HREADYout;
  logic                  REMAP;

  ahb_lite_sn #(.NUM_SLV(NUM_SLV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HWDATA(M_HWDATA),
    .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP), .M_HREADY(M_HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HSEL(HSEL),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADYout(HREADYout), .REMAP(REMAP)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Memory slave models; reset only by the bench so they survive DUT reset pulses.
  logic [31:0] mem   [NUM_SLV][16];
  logic        s_act [NUM_SLV];
  logic        s_wr  [NUM_SLV];
  logic [3:0]  s_idx [NUM_SLV];
  int          s_wc  [NUM_SLV];
  int          wait_cfg [NUM_SLV];

  always @(posedge HCLK or negedge tb_srst_n) begin
    if (!tb_srst_n) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        s_act[i] <= 1'b0;
        s_wr[i]  <= 1'b0;
        s_idx[i] <= '0;
        s_wc[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (s_act[i] && s_wc[i] != 0) begin
          s_wc[i] <= s_wc[i] - 1;
        end else if (HREADY) begin
          if (s_act[i] && s_wr[i]) mem[i][s_idx[i]] <= HWDATA;
          s_act[i] <= HSEL[i] && HTRANS[1];
          s_wr[i]  <= HWRITE;
          s_idx[i] <= HADDR[5:2];
          s_wc[i]  <= wait_cfg[i];
        end
      end
    end
  end

  always_comb begin
    HRDATA    = '0;
    HRESP     = '0;
    HREADYout = '1;
    for (int i = 0; i < NUM_SLV; i++) begin
      HREADYout[i] = !(s_act[i] && s_wc[i] != 0);
      if (s_act[i]) HRDATA[32*i +: 32] = mem[i][s_idx[i]];
    end
  end

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic        dp_busy;
  int          dp_waits;
  logic [1:0]  dp_first;
  logic        dp_first_seen;
  logic [31:0] pend_wdata;
  int          n_vec;
  int          n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at negedge: tracks the data phase at the queue front and retires it on HREADY.
  task automatic observe_dp();
    exp_t e;
    if (dp_busy && sb_q.size() != 0) begin
      if (!dp_first_seen) begin
        dp_first      = M_HRESP;
        dp_first_seen = 1'b1;
      end
      if (!M_HREADY) begin
        dp_waits++;
      end else begin
        e = sb_q.pop_front();
        check_val({e.tag, ".resp"}, 32'(M_HRESP), 32'(e.resp));
        check_val({e.tag, ".waits"}, dp_waits, e.waits);
        if (e.waits > 0)
          check_val({e.tag, ".first_resp"}, 32'(dp_first), 32'((e.resp == c_ERR) ? c_ERR : c_OKAY));
        if (e.chk_data) check_val({e.tag, ".rdata"}, M_HRDATA, e.data);
        dp_busy = 1'b0;
      end
    end
  endtask

  task automatic addr_phase(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                            input logic wr, input logic [31:0] wdata, input logic [2:0] exp_hsel,
                            input logic chk_data, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int exp_waits);
    exp_t e;
    logic rdy;
    int   guard;
    M_HADDR    = addr;
    M_HTRANS   = trans;
    M_HWRITE   = wr;
    M_HWDATA   = pend_wdata;
    pend_wdata = wdata;
    e.chk_data = chk_data;
    e.data     = exp_data;
    e.resp     = exp_resp;
    e.waits    = exp_waits;
    e.tag      = tag;
    sb_q.push_back(e);
    rdy   = 1'b0;
    guard = 0;
    while (!rdy) begin
      @(negedge HCLK);
      if (guard == 0) check_val({tag, ".hsel"}, 32'(HSEL), 32'(exp_hsel));
      observe_dp();
      rdy = M_HREADY;
      @(posedge HCLK);
      #1;
      guard++;
      if (!rdy && guard > 10) begin
        check_val({tag, ".timeout"}, 32'd0, 32'd1);
        rdy = 1'b1;
      end
    end
    dp_busy       = 1'b1;
    dp_waits      = 0;
    dp_first_seen = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    HRESETn = 1'b0;
    #1;
    check_val({tag, ".hready"}, 32'(M_HREADY), 32'd1);
    check_val({tag, ".hresp"},  32'(M_HRESP),  32'd0);
    check_val({tag, ".hrdata"}, M_HRDATA,      32'd0);
    sb_q.delete();
    dp_busy  = 1'b0;
    M_HTRANS = c_IDLE;
    M_HBURST = 3'b000;
    M_HADDR  = 32'h5000_0000;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; dp_busy = 1'b0; dp_waits = 0; dp_first = '0; dp_first_seen = 1'b0;
    pend_wdata = '0;
    for (int i = 0; i < NUM_SLV; i++) wait_cfg[i] = 0;
    HRESETn = 1'b0; tb_srst_n = 1'b0; REMAP = 1'b0;
    M_HADDR = 32'h5000_0000; M_HTRANS = c_IDLE; M_HWRITE = 1'b0; M_HSIZE = 3'b010;
    M_HBURST = 3'b000; M_HPROT = 4'b0011; M_HWDATA = '0;

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_val("rst.hready", 32'(M_HREADY), 32'd1);
    check_val("rst.hresp",  32'(M_HRESP),  32'd0);
    check_val("rst.hrdata", M_HRDATA,      32'd0);
    check_val("rst.hsel",   32'(HSEL),     32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1; tb_srst_n = 1'b1;

    addr_phase("wr_s1", 32'h1000_0004, c_NONSEQ, 1'b1, 32'hCAFE_0001, 3'b010, 1'b0, 32'h0, c_OKAY, 0);
    addr_phase("rd_s1", 32'h1000_0004, c_NONSEQ, 1'b0, 32'h0, 3'b010, 1'b1, 32'hCAFE_0001, c_OKAY, 0);
    addr_phase("wr_s0", 32'h0000_0008, c_NONSEQ, 1'b1, 32'h0BAD_F00D, 3'b001, 1'b0, 32'h0, c_OKAY, 0);
    addr_phase("wr_s2", 32'h2000_0010, c_NONSEQ, 1'b1, 32'h1234_5678, 3'b100, 1'b0, 32'h0, c_OKAY, 0);
    addr_phase("rd_s0", 32'h0000_0008, c_NONSEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'h0BAD_F00D, c_OKAY, 0);
    addr_phase("rd_s2", 32'h2000_0010, c_NONSEQ, 1'b0, 32'h0, 3'b100, 1'b1, 32'h1234_5678, c_OKAY, 0);
    check_val("bcast.ctrl", {20'h0, HSIZE, HBURST, HPROT, HREADY, HWRITE},
              {20'h0, M_HSIZE, M_HBURST, M_HPROT, M_HREADY, M_HWRITE});

    // Unmapped accesses, back-to-back errors, then a mapped slave straight after ERR2.
    addr_phase("err", 32'h5000_0000, c_NONSEQ, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0, c_ERR, 1);
    addr_phase("idle_unmapped", 32'h5000_0000, c_IDLE, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, c_OKAY, 0);
    addr_phase("err_a", 32'h0100_0000, c_NONSEQ, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0, c_ERR, 1);
    addr_phase("err_b", 32'h0FFF_FFFC, c_SEQ, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0, c_ERR, 1);
    addr_phase("rd_after_err", 32'h1000_0004, c_NONSEQ, 1'b0, 32'h0, 3'b010, 1'b1, 32'hCAFE_0001, c_OKAY, 0);
    addr_phase("idle_s0_top", 32'h00FF_FFFC, c_IDLE, 1'b0, 32'h0, 3'b001, 1'b0, 32'h0, c_OKAY, 0);

    wait_cfg[2] = 3;
    addr_phase("rd_s2_wait", 32'h2000_0010, c_NONSEQ, 1'b0, 32'h0, 3'b100, 1'b1, 32'h1234_5678, c_OKAY, 3);
    addr_phase("rd_s0_next", 32'h0000_0008, c_NONSEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'h0BAD_F00D, c_OKAY, 0);
    wait_cfg[2] = 0;

    addr_phase("wr_b0", 32'h0000_0000, c_NONSEQ, 1'b1, 32'hA5A5_0000, 3'b001, 1'b0, 32'h0, c_OKAY, 0);
    addr_phase("wr_b1", 32'h0000_0004, c_NONSEQ, 1'b1, 32'hA5A5_0004, 3'b001, 1'b0, 32'h0, c_OKAY, 0);
    wait_cfg[0] = 2;
    M_HBURST = 3'b011;
    addr_phase("burst_b1", 32'h0000_0000, c_NONSEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'hA5A5_0000, c_OKAY, 2);
    addr_phase("burst_b2", 32'h0000_0004, c_SEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'hA5A5_0004, c_OKAY, 2);
    M_HADDR  = 32'h0000_0008;
    M_HTRANS = c_SEQ;
    #1;
    check_val("burst_pre_rst.hready", 32'(M_HREADY), 32'd0);
    check_val("burst_pre_rst.hrdata", M_HRDATA, 32'hA5A5_0004);
    reset_pulse("burst_rst");
    repeat (3) @(posedge HCLK);
    #1;
    wait_cfg[0] = 0;

    addr_phase("err_c", 32'h5000_0000, c_NONSEQ, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0, c_ERR, 1);
    M_HTRANS = c_IDLE;
    #1;
    check_val("err1_pre_rst.hready", 32'(M_HREADY), 32'd0);
    check_val("err1_pre_rst.hresp",  32'(M_HRESP),  32'(c_ERR));
    reset_pulse("err1_rst");
    addr_phase("post_rst_idle", 32'h5000_0000, c_IDLE, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, c_OKAY, 0);

    REMAP = 1'b1;
`ifdef AHB_LITE_REMAP_EN
    addr_phase("remap1_lo", 32'h0000_0000, c_NONSEQ, 1'b0, 32'h0, 3'b010, 1'b0, 32'h0, c_OKAY, 0);
    addr_phase("remap1_hi", 32'h1000_0004, c_NONSEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'hA5A5_0004, c_OKAY, 0);
`else
    addr_phase("remap1_lo", 32'h0000_0000, c_NONSEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'hA5A5_0000, c_OKAY, 0);
    addr_phase("remap1_hi", 32'h1000_0004, c_NONSEQ, 1'b0, 32'h0, 3'b010, 1'b1, 32'hCAFE_0001, c_OKAY, 0);
`endif
    REMAP = 1'b0;
    addr_phase("remap0_lo", 32'h0000_0000, c_NONSEQ, 1'b0, 32'h0, 3'b001, 1'b1, 32'hA5A5_0000, c_OKAY, 0);
    addr_phase("tail", 32'h5000_0000, c_IDLE, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, c_OKAY, 0);
    @(negedge HCLK);
    observe_dp();
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
